ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares one Hack data RAM (combinational read, write on clock edge, built from DFF registers) between two requesters.
- Port A is the CPU data side; port B is the loader/debug side.
- Per-port req/ack handshake, bus locking for bursts, and a bounded ownership window so neither side starves.
- Sits between the requesters and the RAM address/in/load/out pins.

Parameters:
- ADDR_W, 15, RAM address width.
- DATA_W, 16, data word width.
- MAX_HOLD, 16, max consecutive owned cycles before forced release when the other port is pending (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- a_req  in  1  port A access request; hold with a_we/a_addr/a_wdata stable until a_ack.
- a_lock  in  1  port A asks to keep ownership after the current access.
- a_we  in  1  port A write enable.
- a_addr  in  ADDR_W  port A address.
- a_wdata  in  DATA_W  port A write data.
- a_gnt  out  1  port A owns the RAM (registered).
- a_ack  out  1  port A access accepted this cycle (combinational).
- a_rvalid  out  1  a_rdata valid; pulses the cycle after a read ack.
- a_rdata  out  DATA_W  registered read data.
- b_req, b_lock, b_we, b_addr, b_wdata, b_gnt, b_ack, b_rvalid, b_rdata: identical for port B.
- ram_addr  out  ADDR_W  to RAM address.
- ram_in  out  DATA_W  to RAM write data.
- ram_load  out  1  to RAM write enable.
- ram_out  in  DATA_W  from RAM, combinational read of ram_addr.

Behaviour:
- Reset: clk and reset as named above; reset is synchronous, active-high. Sampled at a rising edge, it forces state=IDLE, hold counter=0, gnt/rvalid=0, rdata=0. ram_load is forced 0 while reset=1, including mid-burst, so no write commits during reset.
- States: IDLE, OWN_A, OWN_B. a_gnt=(state==OWN_A), b_gnt=(state==OWN_B).
- IDLE: ram_load=0, ram_addr/ram_in=0, acks=0. If any req, next state is OWN of the winner. Simultaneous requests go to A (fixed priority).
- Latency: req seen in IDLE at cycle N -> gnt at N+1 -> ack at N+1 if req is still high.
- OWN_x: ram_addr=x_addr, ram_in=x_wdata, ram_load=x_we&x_req. x_ack=x_req. A write commits at the edge ending the ack cycle. A read registers ram_out into x_rdata at that edge and pulses x_rvalid for 1 cycle. Writes leave x_rdata unchanged and give no rvalid. The non-owner's ack is 0.
- Hold counter: cleared on entry to any OWN state, +1 per owned cycle, saturates at MAX_HOLD-1.
- Release from OWN_x, evaluated each cycle, first match wins:
  - (a) other req high and (x_lock=0 or counter==MAX_HOLD-1) -> OWN_other, direct handover with no IDLE bubble.
  - (b) x_req=0 and x_lock=0 -> IDLE.
  - (c) else stay.
- The other port's request is never dropped. It waits with gnt=0 and ack=0.
- Unlocked back-to-back requests with the other port idle stay in OWN_x, giving 1 access per cycle.
- x_lock=1 with x_req=0 holds the bus idle (ram_load=0), bounded by MAX_HOLD only if the other port is pending.
- Handover keeps no state except rdata/rvalid, which belong to the port that issued the read.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined: a 1-bit last_owner register (reset = B, so A still wins the first contest). On simultaneous requests in IDLE, the port that was not last_owner wins. last_owner updates on every OWN entry.
- Undefined: fixed A>B priority in IDLE. Release rules are unchanged in both cases.

Test Plan:
- Reset then A write 0x0005 <- 0x1234, then A read 0x0005 -> gnt_a at N+1, ack_a at N+1, ram_load=1 for exactly one cycle, a_rvalid 1 cycle after read ack with a_rdata=0x1234.
- a_req and b_req asserted same cycle from IDLE, both unlocked -> A acked first, then B acked the next cycle with no IDLE gap. With ARB_ROUND_ROBIN_EN, a second simultaneous contest goes to B.
- A locked burst of 40 reads, b_req raised at burst cycle 3, MAX_HOLD=16 -> A owns exactly 16 cycles, B gets gnt on the next cycle. A's pending req is acked after B releases.
- A locked with a_req=0 and B idle for 30 cycles -> OWN_A held, ram_load=0, no acks. B then requests -> forced handover after the counter reaches MAX_HOLD-1.
- reset asserted in a cycle with a_req=1, a_we=1 to address 0x0007 -> ram_load=0 that cycle, RAM[7] unchanged, gnt/rvalid=0 and rdata=0 after the edge.
- B write to 0x7FFF (max address) with data 0xFFFF, then read back -> b_rdata=0xFFFF, a_rvalid never asserts.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one Hack data RAM between two requesters.
//   Port A is the CPU data side and port B is the loader/debug side.
//   The RAM has a combinational read of ram_addr and writes on the clock edge
//   when ram_load is high.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   - simultaneous requests in IDLE go to the port that did not own
//               the RAM last (the first contest after reset still goes to A)
//   undefined - simultaneous requests in IDLE always go to A
//
// Ports:
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   x_req/x_lock/x_we/x_addr/x_wdata  requester x (a or b) access request
//   x_gnt                           x owns the RAM (registered)
//   x_ack                           x access accepted this cycle (combinational)
//   x_rvalid/x_rdata                read data, valid the cycle after a read ack
//   ram_addr/ram_in/ram_load        to the RAM
//   ram_out                         from the RAM (combinational read of ram_addr)
module ram_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 16,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_lock,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_ack,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_lock,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_ack,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out
);

  localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arbState_t;

  arbState_t        stateR;
  arbState_t        nextStateS;
  logic [CNT_W-1:0] holdCntR;
  logic             holdLastS;
  logic             aGntR;
  logic             bGntR;
  logic             aRvalidR;
  logic             bRvalidR;
  logic [DATA_W-1:0] aRdataR;
  logic [DATA_W-1:0] bRdataR;
  logic             aReadS;
  logic             bReadS;
`ifdef ARB_ROUND_ROBIN_EN
  logic             lastOwnerR;  // 0 = A, 1 = B
`endif

  assign holdLastS = (holdCntR == HOLD_LAST);
  // A read is captured at the edge that ends its ack cycle.
  assign aReadS = (stateR == OWN_A) && a_req && !a_we;
  assign bReadS = (stateR == OWN_B) && b_req && !b_we;

  assign a_gnt    = aGntR;
  assign b_gnt    = bGntR;
  assign a_rvalid = aRvalidR;
  assign b_rvalid = bRvalidR;
  assign a_rdata  = aRdataR;
  assign b_rdata  = bRdataR;

  // Next-state: arbitration in IDLE, release rules while owned (handover first).
  always_comb begin
    nextStateS = stateR;
    case (stateR)
      IDLE: begin
        if (a_req && b_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          if (lastOwnerR) begin
            nextStateS = OWN_A;
          end else begin
            nextStateS = OWN_B;
          end
`else
          nextStateS = OWN_A;
`endif
        end else if (a_req) begin
          nextStateS = OWN_A;
        end else if (b_req) begin
          nextStateS = OWN_B;
        end else begin
          nextStateS = IDLE;
        end
      end
      OWN_A: begin
        if (b_req && (!a_lock || holdLastS)) begin
          nextStateS = OWN_B;
        end else if (!a_req && !a_lock) begin
          nextStateS = IDLE;
        end else begin
          nextStateS = OWN_A;
        end
      end
      OWN_B: begin
        if (a_req && (!b_lock || holdLastS)) begin
          nextStateS = OWN_A;
        end else if (!b_req && !b_lock) begin
          nextStateS = IDLE;
        end else begin
          nextStateS = OWN_B;
        end
      end
      default: nextStateS = IDLE;
    endcase
  end

  // RAM pin mux and acks; ram_load is gated by reset so nothing commits during it.
  always_comb begin
    ram_addr = {ADDR_W{1'b0}};
    ram_in   = {DATA_W{1'b0}};
    ram_load = 1'b0;
    a_ack    = 1'b0;
    b_ack    = 1'b0;
    case (stateR)
      OWN_A: begin
        ram_addr = a_addr;
        ram_in   = a_wdata;
        ram_load = a_we && a_req && !reset;
        a_ack    = a_req;
      end
      OWN_B: begin
        ram_addr = b_addr;
        ram_in   = b_wdata;
        ram_load = b_we && b_req && !reset;
        b_ack    = b_req;
      end
      default: begin
        ram_addr = {ADDR_W{1'b0}};
        ram_in   = {DATA_W{1'b0}};
        ram_load = 1'b0;
        a_ack    = 1'b0;
        b_ack    = 1'b0;
      end
    endcase
  end

  // State, grant flops and hold counter (cleared on any state change, saturating).
  always_ff @(posedge clk) begin
    if (reset) begin
      stateR   <= IDLE;
      aGntR    <= 1'b0;
      bGntR    <= 1'b0;
      holdCntR <= {CNT_W{1'b0}};
    end else begin
      stateR <= nextStateS;
      aGntR  <= (nextStateS == OWN_A);
      bGntR  <= (nextStateS == OWN_B);
      if (nextStateS != stateR) begin
        holdCntR <= {CNT_W{1'b0}};
      end else if ((stateR != IDLE) && !holdLastS) begin
        holdCntR <= holdCntR + CNT_W'(1);
      end else begin
        holdCntR <= holdCntR;
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember which port entered ownership most recently (B after reset).
  always_ff @(posedge clk) begin
    if (reset) begin
      lastOwnerR <= 1'b1;
    end else if ((nextStateS == OWN_A) && (stateR != OWN_A)) begin
      lastOwnerR <= 1'b0;
    end else if ((nextStateS == OWN_B) && (stateR != OWN_B)) begin
      lastOwnerR <= 1'b1;
    end else begin
      lastOwnerR <= lastOwnerR;
    end
  end
`endif

  // Read data capture: rdata/rvalid belong to the port that issued the read.
  always_ff @(posedge clk) begin
    if (reset) begin
      aRvalidR <= 1'b0;
      bRvalidR <= 1'b0;
      aRdataR  <= {DATA_W{1'b0}};
      bRdataR  <= {DATA_W{1'b0}};
    end else begin
      aRvalidR <= aReadS;
      bRvalidR <= bReadS;
      if (aReadS) begin
        aRdataR <= ram_out;
      end else begin
        aRdataR <= aRdataR;
      end
      if (bReadS) begin
        bRdataR <= ram_out;
      end else begin
        bRdataR <= bRdataR;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM and per-port read
// scoreboards (expected words queued at the read ack, popped on rvalid).
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_lock, a_we;
  logic [14:0] a_addr;
  logic [15:0] a_wdata;
  logic        a_gnt, a_ack, a_rvalid;
  logic [15:0] a_rdata;
  logic        b_req, b_lock, b_we;
  logic [14:0] b_addr;
  logic [15:0] b_wdata;
  logic        b_gnt, b_ack, b_rvalid;
  logic [15:0] b_rdata;
  logic [14:0] ram_addr;
  logic [15:0] ram_in;
  logic        ram_load;
  logic [15:0] ram_out;

  logic [15:0] mem [0:32767];
  logic [15:0] qA[$];
  logic [15:0] qB[$];
  int checks = 0;
  int errors = 0;
  int loadCycles = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(15), .DATA_W(16), .MAX_HOLD(16)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_lock(a_lock), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_lock(b_lock), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_addr(ram_addr), .ram_in(ram_in), .ram_load(ram_load), .ram_out(ram_out)
  );

  assign ram_out = mem[ram_addr];

  function automatic logic [15:0] pat(input logic [14:0] addr);
    return {1'b0, addr} ^ 16'h5A3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // RAM model: preloaded pattern, writes on the rising edge.
  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = pat(15'(i));
    forever begin
      @(posedge clk);
      if (ram_load) mem[ram_addr] = ram_in;
    end
  end

  // Read-data scoreboard and write-strobe counter, sampled mid-cycle.
  always @(negedge clk) begin
    if (ram_load === 1'b1) loadCycles++;
    if (a_rvalid === 1'b1) begin
      if (qA.size() == 0) chk("a_rvalid_unexpected", 32'd1, 32'd0);
      else chk("a_rdata_sb", a_rdata, qA.pop_front());
    end
    if (b_rvalid === 1'b1) begin
      if (qB.size() == 0) chk("b_rvalid_unexpected", 32'd1, 32'd0);
      else chk("b_rdata_sb", b_rdata, qB.pop_front());
    end
  end

  initial begin
    int loadBase, acked, aOwn, lastA, firstB, bAcks, bad;
    logic bRaised;
    reset = 1'b1;
    a_req = 1'b0; a_lock = 1'b0; a_we = 1'b0; a_addr = 15'h0; a_wdata = 16'h0;
    b_req = 1'b0; b_lock = 1'b0; b_we = 1'b0; b_addr = 15'h0; b_wdata = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_a_gnt", a_gnt, 0); chk("rst_b_gnt", b_gnt, 0);
    chk("rst_a_rvalid", a_rvalid, 0); chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rdata", b_rdata, 0); chk("rst_load", ram_load, 0);

    // A write 0x0005 <- 0x1234, then read it back
    loadBase = loadCycles;
    a_req = 1'b1; a_we = 1'b1; a_addr = 15'h0005; a_wdata = 16'h1234;
    #1;
    chk("t1_idle_gnt", a_gnt, 0); chk("t1_idle_ack", a_ack, 0);
    cyc(); #1;
    chk("t1_gnt", a_gnt, 1); chk("t1_ack", a_ack, 1); chk("t1_load", ram_load, 1);
    chk("t1_addr", ram_addr, 15'h0005); chk("t1_in", ram_in, 16'h1234); chk("t1_b_ack", b_ack, 0);
    cyc(); a_we = 1'b0; #1;
    chk("t1_read_ack", a_ack, 1); chk("t1_read_load", ram_load, 0);
    qA.push_back(16'h1234);
    cyc(); a_req = 1'b0; #1;
    chk("t1_rvalid", a_rvalid, 1); chk("t1_rdata", a_rdata, 16'h1234);
    cyc(); #1;
    chk("t1_release", a_gnt, 0); chk("t1_rvalid_pulse", a_rvalid, 0);
    chk("t1_load_cycles", loadCycles - loadBase, 1);

    // Simultaneous unlocked writes: A first, B next cycle with no IDLE gap
    a_req = 1'b1; a_we = 1'b1; a_addr = 15'h0010; a_wdata = 16'hAAAA;
    b_req = 1'b1; b_we = 1'b1; b_addr = 15'h0011; b_wdata = 16'hBBBB;
    cyc(); #1;
    chk("t2_a_gnt", a_gnt, 1); chk("t2_a_ack", a_ack, 1); chk("t2_b_gnt_wait", b_gnt, 0); chk("t2_b_ack_wait", b_ack, 0);
    cyc(); a_req = 1'b0; #1;
    chk("t2_a_gnt_off", a_gnt, 0); chk("t2_b_gnt", b_gnt, 1); chk("t2_b_ack", b_ack, 1); chk("t2_b_addr", ram_addr, 15'h0011);
    cyc(); b_req = 1'b0;
    cyc(); #1;
    chk("t2_idle", b_gnt, 0); chk("t2_mem_a", mem[16], 16'hAAAA); chk("t2_mem_b", mem[17], 16'hBBBB);

`ifdef ARB_ROUND_ROBIN_EN
    // A alone first so A is last owner; the next contest goes to B
    a_req = 1'b1; a_we = 1'b1; a_addr = 15'h0012; a_wdata = 16'h1111;
    cyc(); a_req = 1'b0;
    cyc(); #1;
    a_req = 1'b1; a_addr = 15'h0013; b_req = 1'b1; b_we = 1'b1; b_addr = 15'h0014; b_wdata = 16'h2222;
    cyc(); #1;
    chk("rr_b_wins", b_gnt, 1); chk("rr_a_waits", a_gnt, 0);
    cyc(); b_req = 1'b0; #1;
    chk("rr_a_next", a_gnt, 1);
    cyc(); a_req = 1'b0;
    cyc(); cyc(); #1;
`endif

    // Locked 40-read burst by A, B requests at burst cycle 3
    a_req = 1'b1; a_lock = 1'b1; a_we = 1'b0; a_addr = 15'h0100;
    b_we = 1'b0; b_addr = 15'h0200; b_lock = 1'b0;
    acked = 0; aOwn = 0; lastA = -1; firstB = -1; bAcks = 0; bRaised = 1'b0;
    for (int i = 0; i < 150; i++) begin
      cyc();
      if (acked == 40) begin a_req = 1'b0; a_lock = 1'b0; end
      else a_addr = 15'h0100 + 15'(acked);
      if (bAcks > 0) b_req = 1'b0;
      #1;
      if (a_gnt && firstB < 0) begin aOwn++; lastA = i; end
      if (b_gnt && firstB < 0) firstB = i;
      if (a_ack) begin qA.push_back(pat(a_addr)); acked++; end
      if (b_ack) begin qB.push_back(pat(b_addr)); bAcks++; end
      if (aOwn == 3 && !bRaised) begin b_req = 1'b1; bRaised = 1'b1; end
      if (acked == 40 && !a_gnt) break;
    end
    chk("t3_a_own_cycles", aOwn, 16); chk("t3_handover_gap", firstB - lastA, 1);
    chk("t3_b_acks", bAcks, 1); chk("t3_burst_done", acked, 40); chk("t3_idle", a_gnt, 0);

    // A locked but not requesting, B idle for 30 cycles
    a_req = 1'b1; a_lock = 1'b1; a_we = 1'b0; a_addr = 15'h0120;
    cyc(); #1;
    chk("t4_gnt", a_gnt, 1); chk("t4_ack", a_ack, 1);
    qA.push_back(pat(15'h0120));
    cyc(); a_req = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (a_gnt !== 1'b1 || ram_load !== 1'b0 || a_ack !== 1'b0 || b_ack !== 1'b0) bad++;
      cyc();
    end
    chk("t4_lock_hold", bad, 0);
    // B writes max address: handover is immediate, the counter is saturated
    b_req = 1'b1; b_we = 1'b1; b_addr = 15'h7FFF; b_wdata = 16'hFFFF;
    #1;
    chk("t4_b_wait", b_ack, 0);
    cyc(); #1;
    chk("t4_forced_gnt", b_gnt, 1); chk("t4_a_gnt_off", a_gnt, 0);
    chk("t6_load", ram_load, 1); chk("t6_addr", ram_addr, 15'h7FFF);
    cyc(); b_we = 1'b0; #1;
    chk("t6_read_ack", b_ack, 1);
    qB.push_back(16'hFFFF);
    cyc(); b_req = 1'b0; #1;
    chk("t6_b_rvalid", b_rvalid, 1); chk("t6_b_rdata", b_rdata, 16'hFFFF); chk("t6_a_rvalid", a_rvalid, 0);
    a_lock = 1'b0;
    cyc(); #1;
    chk("t6_idle", b_gnt, 0); chk("t6_mem", mem[32767], 16'hFFFF);

    // Reset mid-burst while A drives a write to 0x0007
    a_req = 1'b1; a_lock = 1'b1; a_we = 1'b0; a_addr = 15'h0130;
    qA.push_back(pat(15'h0130));
    cyc(); #1;
    chk("t5_read_ack", a_ack, 1);
    cyc(); a_we = 1'b1; a_addr = 15'h0007; a_wdata = 16'hDEAD; reset = 1'b1; #1;
    chk("t5_load_in_reset", ram_load, 0);
    cyc(); reset = 1'b0; a_req = 1'b0; a_lock = 1'b0; a_we = 1'b0; #1;
    chk("t5_a_gnt", a_gnt, 0); chk("t5_a_rvalid", a_rvalid, 0);
    chk("t5_a_rdata", a_rdata, 0); chk("t5_b_rdata", b_rdata, 0);
    chk("t5_mem7", mem[7], pat(15'h0007));

    cyc(); #1;
    chk("q_a_empty", qA.size(), 0); chk("q_b_empty", qB.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
